// File: rtl/add64_pkg.sv
// Shared constants and state type for the sequential 64-bit slice adder.
package add64_pkg;

  localparam int unsigned WORD_W     = 64;
  localparam int unsigned SLICE_W    = 16;
  localparam int unsigned NUM_SLICES = 4;
  localparam int unsigned K_W        = $clog2(NUM_SLICES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } add64_state_t;

endpackage

// File: rtl/CLA_16.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups with group
// propagate/generate, plus block-level px/gx for chaining by the caller.
module CLA_16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        c0,
  output logic [15:0] S,
  output logic        px,
  output logic        gx
);

  logic [15:0] p, g, c;
  logic [3:0]  grp_p, grp_g, grp_c;

  assign p = A ^ B;
  assign g = A & B;

  // Group propagate/generate for each 4-bit group.
  always_comb begin
    grp_p = '0;
    grp_g = '0;
    for (int j = 0; j < 4; j++) begin
      grp_p[j] = &p[4*j +: 4];
      grp_g[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | ((&p[4*j+1 +: 3]) & g[4*j]);
    end
  end

  // Group carries computed directly from c0 (lookahead, not rippled).
  always_comb begin
    grp_c[0] = c0;
    grp_c[1] = grp_g[0] | (grp_p[0] & c0);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & c0);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & c0);
  end

  // Bit carries inside each group, seeded by that group's carry-in.
  always_comb begin
    c = '0;
    for (int j = 0; j < 4; j++) begin
      c[4*j] = grp_c[j];
      for (int i = 1; i < 4; i++) begin
        c[4*j+i] = g[4*j+i-1] | (p[4*j+i-1] & c[4*j+i-1]);
      end
    end
  end

  assign S  = p ^ c;
  assign px = &grp_p;
  assign gx = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
            | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);

endmodule

// File: rtl/add64_seq.sv
// Sequential 64-bit adder: one 16-bit CLA slice per cycle, valid/ready on
// both sides. Optional overflow output enabled by macro ADD64_SEQ_OVF_EN;
// without it ovf is tied to 0.
module add64_seq
  import add64_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] sum,
  output logic        cout,
  output logic        ovf
);

  add64_state_t state_q, state_d;

  logic [WORD_W-1:0]  a_q, b_q, sum_q, sum_d;
  logic [K_W-1:0]     k_q;
  logic               carry_q;
  logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
  logic               px, gx;
  logic               xfer, last_slice;

  assign xfer       = in_valid & in_ready;
  assign last_slice = (k_q == K_W'(NUM_SLICES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)   state_d = BUSY;
      BUSY:    if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Select operand slice k for the shared CLA.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (k_q == K_W'(i)) begin
        a_sl = a_q[i*SLICE_W +: SLICE_W];
        b_sl = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  CLA_16 u_cla (
    .A  (a_sl),
    .B  (b_sl),
    .c0 (carry_q),
    .S  (s_sl),
    .px (px),
    .gx (gx)
  );

  // Merge the freshly computed slice into the result word.
  always_comb begin
    sum_d = sum_q;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (k_q == K_W'(i)) sum_d[i*SLICE_W +: SLICE_W] = s_sl;
    end
  end

  // Operand capture on transfer, one slice per BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
    end else if (xfer) begin
      a_q     <= a;
      b_q     <= b;
      k_q     <= '0;
      carry_q <= cin;
    end else if (state_q == BUSY) begin
      sum_q   <= sum_d;
      carry_q <= gx | (px & carry_q);
      k_q     <= k_q + K_W'(1);
    end
  end

  assign sum  = sum_q;
  // After the last slice the carry register holds the carry out of bit 63.
  assign cout = carry_q;

`ifdef ADD64_SEQ_OVF_EN
  logic ovf_q;

  // Overflow captured with the top slice, so it stays aligned with sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if ((state_q == BUSY) && last_slice) begin
      ovf_q <= (a_q[WORD_W-1] == b_q[WORD_W-1]) & (s_sl[SLICE_W-1] != a_q[WORD_W-1]);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_add64_seq.sv
// Scoreboard bench for add64_seq: driver pushes expected results from a
// plain-arithmetic model, monitor pops and compares on each output take.
module tb_add64_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [63:0] a, b, sum;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  add64_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic c);
    logic [64:0] full;
    exp_t        e;
    full   = {1'b0, x} + {1'b0, y} + {64'd0, c};
    e.sum  = full[63:0];
    e.cout = full[64];
`ifdef ADD64_SEQ_OVF_EN
    e.ovf  = (x[63] == y[63]) && (e.sum[63] != x[63]);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0b, want %0b", name, act, req);
    end
  endtask

  // Monitor: compare whenever the consumer takes a result on the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check1("unexpected_result", out_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sum", sum, mon_e.sum);
        check1("cout", cout, mon_e.cout);
        check1("ovf", ovf, mon_e.ovf);
      end
    end
  end

  // Offer an operand pair, complete the transfer, then scramble the inputs.
  task automatic start(input logic [63:0] x, input logic [63:0] y, input logic c,
                       input logic junk_valid);
    int t;
    t        = 0;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = c;
    while (!in_ready && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check1("in_ready_wait", in_ready, 1'b1);
    @(posedge clk);
    exp_q.push_back(model(x, y, c));
    #1;
    in_valid = junk_valid;
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    cin      = 1'($urandom);
  endtask

  task automatic wait_done();
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd4);
  endtask

  task automatic collect(input int hold);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check1("hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check1("idle_after_take", in_ready, 1'b1);
    check1("valid_dropped", out_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [63:0] x, y, x2, y2;
    logic        c;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 64'd0);
    check1("rst_cout", cout, 1'b0);
    check1("rst_ovf", ovf, 1'b0);

    // Transfer immediately followed by reset: nothing must come out.
    start(64'd1, 64'd1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    check1("rst2_in_ready", in_ready, 1'b1);
    check1("rst2_out_valid", out_valid, 1'b0);
    check("rst2_sum", sum, 64'd0);
    check1("rst2_cout", cout, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check1("rst2_quiet", out_valid, 1'b0);

    // Directed corner cases.
    start(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0);
    wait_done();
    collect(0);
    start(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
    wait_done();
    collect(1);
    start(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    wait_done();
    collect(0);
    start(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    wait_done();
    collect(0);

    // Backpressure with a competing input offer held high.
    x  = {$urandom, $urandom};
    y  = {$urandom, $urandom};
    c  = 1'($urandom);
    x2 = {$urandom, $urandom};
    y2 = {$urandom, $urandom};
    e  = model(x, y, c);
    start(x, y, c, 1'b0);
    wait_done();
    in_valid = 1'b1;
    a        = x2;
    b        = y2;
    cin      = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      check1("bp_valid", out_valid, 1'b1);
      check1("bp_in_ready", in_ready, 1'b0);
      check("bp_sum", sum, e.sum);
      check1("bp_cout", cout, e.cout);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check1("bp_second_pending", in_ready, 1'b1);
    check("bp_queue_drained", 64'(exp_q.size()), 64'd0);
    start(x2, y2, 1'b1, 1'b0);
    wait_done();
    collect(2);

    // Reset on the second BUSY edge, then a clean 3 + 4.
    start({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    check1("mid_rst_in_ready", in_ready, 1'b1);
    check1("mid_rst_out_valid", out_valid, 1'b0);
    start(64'd3, 64'd4, 1'b0, 1'b0);
    wait_done();
    check("mid_rst_sum7", sum, 64'd7);
    collect(0);

    // Randomized traffic, with junk offers while busy.
    for (int n = 0; n < 40; n++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) y = ~x;
      if ($urandom_range(0, 5) == 0) x = {1'b0, {63{1'b1}}};
      c = 1'($urandom);
      start(x, y, c, 1'($urandom));
      wait_done();
      collect(int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("pending", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
